// File: rtl/dma_pkg.sv
// Shared types and constants for the object DMA sequencer.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WRITE,
        REL
    } dma_state_t;

    localparam logic [11:0] DEF_BASE_ADDR = 12'h000;
    localparam logic [11:0] DEF_BANK_OFS  = 12'h200;

    // Never returns less than 1 so single-entry counters still get a bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/dma_obj_pack.sv
// Byte-lane packer: collects one object's bytes into a single word, byte 0 in the low lane.
module dma_obj_pack
    import dma_pkg::*;
#(
    parameter int OBJ_BYTES = 4,
    localparam int LW = clog2(OBJ_BYTES)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_load,
    input  logic [LW-1:0]          i_lane,
    input  logic [7:0]             i_byte,
    output logic [8*OBJ_BYTES-1:0] o_word
);

    logic [OBJ_BYTES-1:0][7:0] r_word;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_word <= '0;
        end else begin
            for (int i = 0; i < OBJ_BYTES; i++) begin
                if (i_load && (i_lane == LW'(i))) r_word[i] <= i_byte;
            end
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/dma_obj_sched.sv
// Object DMA sequencer: arm on bank write, take the Z80 bus at VB start, copy sprite RAM to the line buffer.
// Optional REQ watchdog with ERR flag enabled by defining DMA_TIMEOUT_EN.
module dma_obj_sched
    import dma_pkg::*;
#(
    parameter int          N_OBJ     = 128,
    parameter int          OBJ_BYTES = 4,
    parameter logic [11:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [11:0] BANK_OFS  = DEF_BANK_OFS,
    parameter int          RD_CYC    = 3,
    parameter int          TIMEOUT   = 4096,
    localparam int OAW = clog2(N_OBJ),
    localparam int BW  = clog2(OBJ_BYTES),
    localparam int CW  = clog2(RD_CYC + 1)
) (
    input  logic                   CLK20,
    input  logic                   RESET,
    input  logic                   VB,
    input  logic                   DWRBKn,
    input  logic [7:0]             DD_IN,
    input  logic                   BUSAK_n,
    output logic                   BUSRQn,
    output logic [11:0]            AD_OUT,
    output logic                   AD_OE,
    output logic                   RDn,
    output logic                   OBJ_WE,
    output logic [OAW-1:0]         OBJ_ADDR,
    output logic [8*OBJ_BYTES-1:0] OBJ_DATA,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR
);

    localparam logic [OAW-1:0] LAST_OBJ  = OAW'(N_OBJ - 1);
    localparam logic [BW-1:0]  LAST_BYTE = BW'(OBJ_BYTES - 1);
    localparam logic [CW-1:0]  RD_LAST   = CW'(RD_CYC - 1);
    localparam logic [CW-1:0]  RD_GAP    = CW'(RD_CYC);

    dma_state_t     r_state, w_state_nx;
    logic           r_dwr_q, r_vb_q, r_armed, r_bank_arm, r_bank, r_done;
    logic [OAW-1:0] r_obj;
    logic [BW-1:0]  r_byte;
    logic [CW-1:0]  r_rd;
    logic           w_arm, w_start, w_xfer, w_go, w_load, w_tmo, w_abort;
    logic [11:0]    w_addr;

    assign w_arm   = r_dwr_q & ~DWRBKn;
    assign w_start = VB & ~r_vb_q & r_armed & (r_state == IDLE);
    assign w_xfer  = (r_state == READ) || (r_state == WRITE);
    // Progress only while the bus is actually granted; otherwise everything holds.
    assign w_go    = w_xfer & ~BUSAK_n;
    assign w_load  = w_go && (r_state == READ) && (r_rd == RD_LAST);
    assign w_addr  = BASE_ADDR + (r_bank ? BANK_OFS : 12'h000)
                   + 12'(int'(r_obj) * OBJ_BYTES) + 12'(r_byte);

`ifdef DMA_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_err, r_abort;

    assign w_tmo = (r_state == REQ) && BUSAK_n && (r_tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge CLK20) begin
        if (RESET) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            if (r_state != REQ)  r_tmo_cnt <= '0;
            else if (BUSAK_n)    r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_tmo) begin
                r_err   <= 1'b1;
                r_abort <= 1'b1;
            end else if (w_start) begin
                r_abort <= 1'b0;
            end
            if (w_arm) r_err <= 1'b0;
        end
    end

    assign w_abort = r_abort;
    assign ERR     = r_err;
`else
    localparam int tmo_unused = TIMEOUT;
    assign w_tmo   = 1'b0;
    assign w_abort = 1'b0;
    assign ERR     = 1'b0;
`endif

    always_ff @(posedge CLK20) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:  if (w_start) w_state_nx = REQ;
            REQ: begin
                if (!BUSAK_n)   w_state_nx = READ;
                else if (w_tmo) w_state_nx = REL;
            end
            READ:  if (w_go && (r_rd == RD_GAP) && (r_byte == LAST_BYTE)) w_state_nx = WRITE;
            WRITE: if (w_go) w_state_nx = (r_obj == LAST_OBJ) ? REL : READ;
            REL:   if (BUSAK_n) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK20) begin
        if (RESET) begin
            r_dwr_q    <= 1'b1;
            r_vb_q     <= 1'b0;
            r_armed    <= 1'b0;
            r_bank_arm <= 1'b0;
            r_bank     <= 1'b0;
            r_done     <= 1'b0;
            r_obj      <= '0;
            r_byte     <= '0;
            r_rd       <= '0;
        end else begin
            r_dwr_q <= DWRBKn;
            r_vb_q  <= VB;
            r_done  <= (r_state == REL) && BUSAK_n && !w_abort;
            // Start consumes the arm; an arm in the same cycle re-arms for the next frame.
            if (w_start) begin
                r_armed <= 1'b0;
                r_bank  <= r_bank_arm;
            end
            if (w_arm) begin
                r_armed    <= 1'b1;
                r_bank_arm <= DD_IN[0];
            end
            if (w_start) begin
                r_obj  <= '0;
                r_byte <= '0;
                r_rd   <= '0;
            end else if (w_go) begin
                if (r_state == READ) begin
                    if (r_rd == RD_GAP) begin
                        r_rd <= '0;
                        if (r_byte != LAST_BYTE) r_byte <= r_byte + 1'b1;
                    end else begin
                        r_rd <= r_rd + 1'b1;
                    end
                end else begin
                    r_byte <= '0;
                    r_obj  <= (r_obj == LAST_OBJ) ? '0 : r_obj + 1'b1;
                end
            end
        end
    end

    dma_obj_pack #(.OBJ_BYTES(OBJ_BYTES)) u_pack (
        .i_clk  (CLK20),
        .i_rst  (RESET),
        .i_clr  (w_start),
        .i_load (w_load),
        .i_lane (r_byte),
        .i_byte (DD_IN),
        .o_word (OBJ_DATA)
    );

    assign BUSRQn   = !((r_state == REQ) || w_xfer);
    assign AD_OE    = w_go;
    assign RDn      = !(w_go && (r_state == READ) && (r_rd != RD_GAP));
    assign OBJ_WE   = w_go && (r_state == WRITE);
    assign OBJ_ADDR = r_obj;
    assign AD_OUT   = w_xfer ? w_addr : 12'h000;
    assign BUSY     = (r_state != IDLE);
    assign DONE     = r_done;

endmodule

// File: tb/tb_dma_obj_sched.sv
// Randomized bench for dma_obj_sched: sprite-RAM model, Z80 bus-ack model and a transfer scoreboard.
module tb_dma_obj_sched;

    localparam int N = 128;
`ifdef DMA_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 4096;
`endif

    logic        clk = 1'b0;
    logic        RESET, VB, DWRBKn, BUSAK_n;
    logic [7:0]  DD_IN, dd_cpu;
    logic        BUSRQn, AD_OE, RDn, OBJ_WE, BUSY, DONE, ERR;
    logic [11:0] AD_OUT;
    logic [6:0]  OBJ_ADDR;
    logic [31:0] OBJ_DATA;

    logic [7:0]  mem [4096];
    logic        hold;
    int          ack_dly, ack_cnt;
    int          n_chk = 0, n_pass = 0;

    logic [11:0] rd_q [$];
    logic [6:0]  wa_q [$];
    logic [31:0] wd_q [$];
    int          busy_cnt, rqlow_cnt, oe_cnt, rdlow_cnt, viol_cnt, done_cnt;

    always #5 clk = ~clk;

    assign DD_IN = !RDn ? mem[AD_OUT] : dd_cpu;

    dma_obj_sched #(.N_OBJ(N), .TIMEOUT(TMO)) dut (
        .CLK20(clk), .RESET(RESET), .VB(VB), .DWRBKn(DWRBKn), .DD_IN(DD_IN),
        .BUSAK_n(BUSAK_n), .BUSRQn(BUSRQn), .AD_OUT(AD_OUT), .AD_OE(AD_OE),
        .RDn(RDn), .OBJ_WE(OBJ_WE), .OBJ_ADDR(OBJ_ADDR), .OBJ_DATA(OBJ_DATA),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [11:0] ea(input bit bank, input int o, input int b);
        return 12'(((bank ? 512 : 0) + 4 * o + b) % 4096);
    endfunction

    function automatic logic [31:0] exp_word(input bit bank, input int o);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = mem[ea(bank, o, b)];
        return w;
    endfunction

    // Z80 side: grants ack_dly cycles after request, drops the grant when asked to steal the bus back.
    initial begin
        BUSAK_n = 1'b1;
        ack_cnt = 0;
        forever begin
            @(posedge clk); #2;
            if (BUSRQn || hold) begin
                BUSAK_n = 1'b1;
                if (BUSRQn) ack_cnt = 0;
            end else if (ack_cnt >= ack_dly) begin
                BUSAK_n = 1'b0;
            end else begin
                ack_cnt++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (BUSY)    busy_cnt++;
        if (!BUSRQn) rqlow_cnt++;
        if (AD_OE)   oe_cnt++;
        if (!RDn) begin
            rdlow_cnt++;
            if (rd_q.size() == 0 || rd_q[$] != AD_OUT) rd_q.push_back(AD_OUT);
        end
        if ((AD_OE && BUSAK_n) || (!RDn && !AD_OE) || (OBJ_WE && !AD_OE)) viol_cnt++;
        if (OBJ_WE) begin
            wa_q.push_back(OBJ_ADDR);
            wd_q.push_back(OBJ_DATA);
        end
        if (DONE) done_cnt++;
    end

    task automatic clr_mon();
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        busy_cnt = 0; rqlow_cnt = 0; oe_cnt = 0; rdlow_cnt = 0; viol_cnt = 0; done_cnt = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input bit do_arm, input bit bank);
        if (do_arm) begin
            dd_cpu = {7'd0, bank};
            DWRBKn = 1'b0; step(1);
            DWRBKn = 1'b1; step(2);
        end
        VB = 1'b1; step(4);
        VB = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (BUSY && k < bound);
        chk(tag, BUSY, 0);
        step(2);
    endtask

    task automatic find_addr(input logic [11:0] a, input string tag);
        int k;
        bit found;
        k = 0; found = 0;
        while (!found && k < 4000) begin
            @(negedge clk); k++;
            found = !RDn && (AD_OUT == a);
        end
        chk(tag, found, 1);
    endtask

    task automatic verify_xfer(input bit bank, input string tag);
        int bad_w, bad_r;
        bad_w = 0; bad_r = 0;
        chk({tag, "_we_cnt"}, wa_q.size(), N);
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] != 7'(i) || wd_q[i] != exp_word(bank, i)) bad_w++;
        chk({tag, "_wr_bad"}, bad_w, 0);
        chk({tag, "_rd_cnt"}, rd_q.size(), 4 * N);
        for (int i = 0; i < rd_q.size(); i++)
            if (rd_q[i] != ea(bank, i / 4, i % 4)) bad_r++;
        chk({tag, "_rd_bad"}, bad_r, 0);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_oe_cyc"}, oe_cnt, N * 17);
        chk({tag, "_rdlow"}, rdlow_cnt, N * 4 * 3);
        chk({tag, "_bus_viol"}, viol_cnt, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stall_bad;
        bit bank;
        RESET = 1'b1; VB = 1'b0; DWRBKn = 1'b1; dd_cpu = 8'h00; hold = 1'b0; ack_dly = 2;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        clr_mon();
        step(3);
        @(negedge clk);
        chk("rst_busrq", BUSRQn, 1);
        chk("rst_adoe", AD_OE, 0);
        chk("rst_rdn", RDn, 1);
        chk("rst_we", OBJ_WE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_adout", AD_OUT, 0);
        chk("rst_oaddr", OBJ_ADDR, 0);
        chk("rst_odata", OBJ_DATA, 0);
        step(1);
        RESET = 1'b0;
        step(2);

        // VB edge without an arm
        clr_mon();
        start_xfer(0, 0); step(20);
        chk("noarm_busy", busy_cnt, 0);
        chk("noarm_busrq", rqlow_cnt, 0);

        // Bank 0, grant two cycles after request
        clr_mon();
        start_xfer(1, 0);
        wait_idle(5000, "t1_idle");
        verify_xfer(0, "t1");
        chk("t1_first_addr", (rd_q.size() > 0) ? 32'(rd_q[0]) : 32'hFFFF_FFFF, 12'h000);

        // Second VB after completion, no re-arm
        clr_mon();
        start_xfer(0, 0); step(20);
        chk("rearm_busy", busy_cnt, 0);

        // Bus stolen during obj 40, CPU re-arms bank 1 while it owns the bus
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        ack_dly = int'($urandom_range(0, 4));
        clr_mon();
        start_xfer(1, 0);
        find_addr(ea(0, 40, 1), "t4_find");
        @(posedge clk); #1;
        hold = 1'b1;
        stall_bad = 0;
        dd_cpu = 8'h01;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            DWRBKn = (k == 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (AD_OE || !RDn) stall_bad++;
        end
        @(posedge clk); #1;
        hold = 1'b0;
        DWRBKn = 1'b1;
        wait_idle(5000, "t4_idle");
        chk("t4_stall_bus", stall_bad, 0);
        verify_xfer(0, "t4");

        // The mid-transfer arm runs the next frame from bank 1
        clr_mon();
        start_xfer(0, 0);
        wait_idle(5000, "t4b_idle");
        verify_xfer(1, "t4b");

        // Bank 1 with address-pattern memory
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
        clr_mon();
        start_xfer(1, 1);
        wait_idle(5000, "t2_idle");
        verify_xfer(1, "t2");
        chk("t2_obj5_data", (wd_q.size() > 5) ? wd_q[5] : 32'h0, 32'h17161514);
        chk("t2_obj5_a0", (rd_q.size() > 23) ? 32'(rd_q[20]) : 32'h0, 12'h214);
        chk("t2_obj5_a3", (rd_q.size() > 23) ? 32'(rd_q[23]) : 32'h0, 12'h217);

        for (int it = 0; it < 2; it++) begin
            for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
            bank = 1'($urandom_range(0, 1));
            ack_dly = int'($urandom_range(0, 5));
            clr_mon();
            start_xfer(1, bank);
            wait_idle(5000, "rnd_idle");
            verify_xfer(bank, $sformatf("rnd%0d", it));
        end

        // Reset mid-transfer
        bank = 1'($urandom_range(0, 1));
        clr_mon();
        start_xfer(1, bank);
        find_addr(ea(bank, 60, 0), "t5_find");
        @(posedge clk); #1;
        RESET = 1'b1; step(1);
        RESET = 1'b0;
        @(negedge clk);
        chk("t5_busrq", BUSRQn, 1);
        chk("t5_adoe", AD_OE, 0);
        chk("t5_busy", BUSY, 0);
        chk("t5_rdn", RDn, 1);
        chk("t5_odata", OBJ_DATA, 0);
        step(5);
        clr_mon();
        start_xfer(0, 0); step(30);
        chk("t5_noarm_busy", busy_cnt, 0);

`ifdef DMA_TIMEOUT_EN
        hold = 1'b1;
        clr_mon();
        start_xfer(1, 0);
        wait_idle(500, "t6_idle");
        chk("t6_req_cycles", rqlow_cnt, TMO);
        chk("t6_err", ERR, 1);
        chk("t6_done", done_cnt, 0);
        chk("t6_we", wa_q.size(), 0);
        hold = 1'b0;
        dd_cpu = 8'h00;
        DWRBKn = 1'b0; step(1);
        DWRBKn = 1'b1; step(2);
        chk("t6_err_clr", ERR, 0);
`else
        chk("err_tied", ERR, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
